// File: rtl/data_mem_mmio.sv
// ============================================================================
// Module   : data_mem_mmio
// Brief    : Beta data-memory stage: word-addressed block RAM plus an I/O page
//            holding switches, LEDs, hex display word and a cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_mmio #(
  parameter int          RAM_AW  = 10,
  parameter logic [31:0] IO_BASE = 32'hFFFF_FF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ma,
  input  logic [31:0] mwd,
  input  logic        moe,
  input  logic        mwr,
  output logic [31:0] mrd,
  output logic        mrdy,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic [31:0] hex_out
);

  localparam logic [7:0] C_OFF_SW  = 8'h00;
  localparam logic [7:0] C_OFF_LED = 8'h04;
  localparam logic [7:0] C_OFF_HEX = 8'h08;
  localparam logic [7:0] C_OFF_CYC = 8'h0C;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_RD_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_ram [0:(1<<RAM_AW)-1];
  logic [31:0] r_ram_q;
  logic [31:0] r_io_q;
  logic        r_rd_io;
  logic [31:0] r_mrd_last;
  logic [15:0] r_sw_meta;
  logic [15:0] r_sw_sync;
  logic [31:0] r_cyc;
  logic [15:0] r_led;
  logic [31:0] r_hex;

  logic              w_is_io;
  logic [31:0]       w_io_rel;
  logic [7:0]        w_io_off;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_idle;
  logic              w_wr;
  logic              w_rd_start;
  logic              w_wr_ram;
  logic              w_wr_led;
  logic              w_wr_hex;
  logic              w_wr_cyc;
  logic [31:0]       w_io_rdata;
  logic [31:0]       w_rd_data;
  logic              w_mrdy;
  logic              w_unused;

  assign w_is_io   = (ma >= IO_BASE);
  assign w_io_rel  = ma - IO_BASE;
  assign w_io_off  = {w_io_rel[7:2], 2'b00};
  assign w_ram_idx = ma[RAM_AW+1:2];
  assign w_unused  = ^{w_io_rel[31:8], w_io_rel[1:0]};

  // Strobes are gated by reset so nothing commits while reset is asserted.
  assign w_idle     = (r_state == S_IDLE);
  assign w_wr       = reset & w_idle & mwr;
  assign w_rd_start = reset & w_idle & moe & ~mwr;
  assign w_wr_ram   = w_wr & ~w_is_io;
  assign w_wr_led   = w_wr & w_is_io & (w_io_off == C_OFF_LED);
  assign w_wr_hex   = w_wr & w_is_io & (w_io_off == C_OFF_HEX);
  assign w_wr_cyc   = w_wr & w_is_io & (w_io_off == C_OFF_CYC);

  always_comb begin
    w_io_rdata = 32'h0;
    case (w_io_off)
      C_OFF_SW:  w_io_rdata = {16'h0, r_sw_sync};
      C_OFF_LED: w_io_rdata = {16'h0, r_led};
      C_OFF_HEX: w_io_rdata = r_hex;
      C_OFF_CYC: w_io_rdata = r_cyc;
      default:   w_io_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_wr_ram) begin
      r_ram[w_ram_idx] <= mwd;
    end
    if (w_rd_start) begin
      r_ram_q <= r_ram[w_ram_idx];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_io_q  <= 32'h0;
      r_rd_io <= 1'b0;
    end else if (w_rd_start) begin
      r_io_q  <= w_io_rdata;
      r_rd_io <= w_is_io;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sw_meta <= 16'h0;
      r_sw_sync <= 16'h0;
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cyc <= 32'h0;
    end else if (w_wr_cyc) begin
      r_cyc <= 32'h0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_led <= 16'h0;
      r_hex <= 32'h0;
    end else begin
      if (w_wr_led) r_led <= mwd[15:0];
      if (w_wr_hex) r_hex <= mwd;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_mrdy = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_wr) begin
          w_mrdy = 1'b1;
        end else if (w_rd_start) begin
          w_next = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        w_mrdy = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_rd_data = r_rd_io ? r_io_q : r_ram_q;

  // mrd keeps the last completed read once the access returns to idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mrd_last <= 32'h0;
    end else if (r_state == S_RD_WAIT) begin
      r_mrd_last <= w_rd_data;
    end
  end

  assign mrd     = (r_state == S_RD_WAIT) ? w_rd_data : r_mrd_last;
  assign mrdy    = w_mrdy & reset;
  assign led_out = r_led;
  assign hex_out = r_hex;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_mmio.sv
// ============================================================================
// Module   : tb_data_mem_mmio
// Brief    : Self-checking bench for data_mem_mmio with directed and random
//            accesses compared against a behavioural memory/I-O model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_mmio;

  localparam logic [31:0] C_IO = 32'hFFFF_FF00;

  logic        clock;
  logic        reset;
  logic [31:0] ma;
  logic [31:0] mwd;
  logic        moe;
  logic        mwr;
  logic [31:0] mrd;
  logic        mrdy;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic [31:0] hex_out;

  int checks;
  int errors;

  // Reference model state
  logic [31:0] m_ram [0:1023];
  bit          m_vld [0:1023];
  logic [15:0] m_led;
  logic [31:0] m_hex;
  logic [15:0] m_sw;
  longint      m_cyc_t;

  data_mem_mmio #(.RAM_AW(10), .IO_BASE(C_IO)) dut (
    .clock   (clock),
    .reset   (reset),
    .ma      (ma),
    .mwd     (mwd),
    .moe     (moe),
    .mwr     (mwr),
    .mrd     (mrd),
    .mrdy    (mrdy),
    .sw_in   (sw_in),
    .led_out (led_out),
    .hex_out (hex_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read data; CYC value is the count of edges since the clearing edge,
  // sampled at the latch edge (time tl), i.e. one less than edges elapsed.
  function automatic logic [31:0] model_read(input logic [31:0] a, input longint tl);
    logic [7:0] off;
    off = {a[7:2], 2'b00};
    if (a >= C_IO) begin
      case (off)
        8'h00:   return {16'h0, m_sw};
        8'h04:   return {16'h0, m_led};
        8'h08:   return m_hex;
        8'h0C:   return 32'((tl - m_cyc_t) / 10 - 1);
        default: return 32'h0;
      endcase
    end
    return m_ram[a[11:2]];
  endfunction

  // Called at a negedge; returns at the following negedge with strobes low.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    ma = a; mwd = d; mwr = 1'b1; moe = 1'b0;
    #1 chk("wr_mrdy", {31'h0, mrdy}, 32'h1);
    @(posedge clock);
    if (a >= C_IO) begin
      case ({a[7:2], 2'b00})
        8'h04:   m_led = d[15:0];
        8'h08:   m_hex = d;
        8'h0C:   m_cyc_t = $time;
        default: ;
      endcase
    end else begin
      m_ram[a[11:2]] = d;
      m_vld[a[11:2]] = 1'b1;
    end
    @(negedge clock);
    mwr = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input string tag);
    logic [31:0] exp;
    ma = a; moe = 1'b1; mwr = 1'b0;
    #1 chk({tag, "_wait"}, {31'h0, mrdy}, 32'h0);
    @(posedge clock);
    exp = model_read(a, $time);
    @(negedge clock);
    chk({tag, "_rdy"}, {31'h0, mrdy}, 32'h1);
    chk(tag, mrd, exp);
    ma = $urandom;
    @(negedge clock);
    moe = 1'b0;
    #1 chk({tag, "_hold"}, mrd, exp);
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          sel;
    checks = 0; errors = 0;
    m_led = 16'h0; m_hex = 32'h0; m_sw = 16'h0; m_cyc_t = 0;
    for (int i = 0; i < 1024; i++) begin m_vld[i] = 1'b0; m_ram[i] = 32'h0; end
    reset = 1'b0; ma = 32'h0; mwd = 32'h0; moe = 1'b0; mwr = 1'b0; sw_in = 16'h0;

    #2;
    chk("rst_mrdy", {31'h0, mrdy}, 32'h0);
    chk("rst_mrd", mrd, 32'h0);
    chk("rst_led", {16'h0, led_out}, 32'h0);
    chk("rst_hex", hex_out, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // RAM write/read, address wrap and byte-offset aliasing
    do_write(32'h40, 32'hDEADBEEF);
    do_read(32'h40, "ram40");
    do_write(32'h1000, 32'h0000_1234);
    do_read(32'h0000, "wrap0");
    do_read(32'h43, "alias43");

    // I/O registers
    do_write(C_IO + 32'h04, 32'hABCD_5A5A);
    chk("led", {16'h0, led_out}, 32'h0000_5A5A);
    do_write(C_IO + 32'h08, 32'h0123_4567);
    chk("hex", hex_out, 32'h0123_4567);
    do_write(C_IO + 32'h00, 32'hFFFF_FFFF);
    chk("sw_wr_led", {16'h0, led_out}, 32'h0000_5A5A);
    chk("sw_wr_hex", hex_out, 32'h0123_4567);
    do_read(C_IO + 32'h40, "io_unmapped");
    do_read(C_IO + 32'h04, "led_rd");
    do_read(C_IO + 32'h08, "hex_rd");

    // Switch synchroniser
    sw_in = 16'h00F0; m_sw = 16'h00F0;
    repeat (3) @(negedge clock);
    do_read(C_IO + 32'h00, "sw");

    // Cycle counter: clear then read after various idle gaps
    for (int n = 0; n < 4; n++) begin
      do_write(C_IO + 32'h0C, 32'h5555_5555);
      repeat (n * 3) @(negedge clock);
      do_read(C_IO + 32'h0C, "cyc");
    end

    // Randomised mix of RAM and I/O accesses
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 9) begin
        sw_in = 16'($urandom);
        m_sw = sw_in;
        repeat (3) @(negedge clock);
      end
      if (sel < 4) begin
        a = {$urandom_range(0, 3) == 0 ? 20'($urandom) & 20'h7FFFF : 20'h0,
             $urandom_range(0, 1023) == 0 ? 10'h0 : 10'($urandom), 2'($urandom)};
        d = $urandom;
        do_write(a, d);
      end else if (sel < 7) begin
        a = {20'($urandom) & 20'h7FFFF, 10'($urandom), 2'($urandom)};
        if (m_vld[a[11:2]]) do_read(a, "rnd_ram");
      end else begin
        a = C_IO + {24'h0, 8'($urandom_range(0, 4) * 4)} + {30'h0, 2'($urandom)};
        if (($urandom & 1) == 1) begin
          d = $urandom;
          do_write(a, d);
          chk("rnd_led", {16'h0, led_out}, {16'h0, m_led});
          chk("rnd_hex", hex_out, m_hex);
        end else begin
          do_read(a, "rnd_io");
        end
      end
    end

    // Reset asserted during the read wait state
    ma = 32'h40; moe = 1'b1;
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rrst_mrdy", {31'h0, mrdy}, 32'h0);
    chk("rrst_mrd", mrd, 32'h0);
    chk("rrst_led", {16'h0, led_out}, 32'h0);
    chk("rrst_hex", hex_out, 32'h0);
    m_led = 16'h0; m_hex = 32'h0;
    @(negedge clock);
    moe = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("post_rst_mrdy", {31'h0, mrdy}, 32'h0);
    end
    do_read(32'h40, "ram_kept");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
